// File: rtl/synapse_feeder.sv
// synapse_feeder: streams one dot-product vector into a downstream MAC stage.
// Activations arrive on a valid/ready handshake.  Each accepted activation is
// paired with weight[idx] from a small local memory and presented to the MAC
// exactly one cycle later, with first/last markers.  Operands pass bit-exact.
module synapse_feeder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  input  logic          start,
  input  logic [AW:0]   vec_len,
  input  logic          act_valid,
  input  logic [31:0]   act_data,
  output logic          act_ready,
  output logic          mac_ivalid,
  output logic          mac_control,
  output logic [31:0]   mac_a,
  output logic [31:0]   mac_b,
  output logic          mac_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  // Weight storage; deliberately has no reset so weights survive a reset.
  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0] len_q, len_d;
  logic        ivalid_q, ivalid_d;
  logic        ctrl_q, ctrl_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic accept_s;
  logic is_last_s;
  logic len_ok_s;

  // Weight write port: only honoured while idle so a running vector sees stable weights.
  always_ff @(posedge clock) begin
    if (w_we && (state_q == S_IDLE)) begin
      mem[w_addr] <= w_data;
    end
  end

  // Next-state and next-output logic; the weight read lands in b_q, giving a synchronous read.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    ivalid_d = 1'b0;
    ctrl_d   = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    a_d      = a_q;
    b_d      = b_q;

    accept_s  = act_valid && (state_q == S_RUN);
    is_last_s = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));
    len_ok_s  = (vec_len != '0) && (vec_len <= DEPTH_L);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok_s) begin
            state_d = S_RUN;
            len_d   = vec_len;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          ivalid_d = 1'b1;
          ctrl_d   = (idx_q == '0);
          last_d   = is_last_s;
          done_d   = is_last_s;
          a_d      = act_data;
          b_d      = mem[idx_q];
          if (is_last_s) begin
            // idx holds at len-1 so it never wraps inside a vector.
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      ivalid_q <= 1'b0;
      ctrl_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      ivalid_q <= ivalid_d;
      ctrl_q   <= ctrl_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  // Status outputs decode the state register only, so act_ready has no path from act_valid.
  assign act_ready   = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign mac_ivalid  = ivalid_q;
  assign mac_control = ctrl_q;
  assign mac_last    = last_q;
  assign mac_a       = a_q;
  assign mac_b       = b_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_synapse_feeder.sv
// Directed self-checking bench for synapse_feeder.
module tb_synapse_feeder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4 = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F5 = 32'h40A0_0000;  // 5.0
  localparam logic [31:0] F9 = 32'h4110_0000;  // 9.0

  logic          clock = 1'b0;
  logic          reset;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          start;
  logic [AW:0]   vec_len;
  logic          act_valid;
  logic [31:0]   act_data;
  logic          act_ready, mac_ivalid, mac_control, mac_last, busy, done, err;
  logic [31:0]   mac_a, mac_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] wtab [5];

  synapse_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .start(start), .vec_len(vec_len),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .mac_ivalid(mac_ivalid), .mac_control(mac_control),
    .mac_a(mac_a), .mac_b(mac_b), .mac_last(mac_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all status/handshake outputs at once.
  task automatic chk_st(input string tag, input logic rdy, input logic bsy,
                        input logic iv, input logic ctl, input logic lst,
                        input logic dn, input logic er);
    chk({tag, ".act_ready"},   {31'd0, act_ready},   {31'd0, rdy});
    chk({tag, ".busy"},        {31'd0, busy},        {31'd0, bsy});
    chk({tag, ".mac_ivalid"},  {31'd0, mac_ivalid},  {31'd0, iv});
    chk({tag, ".mac_control"}, {31'd0, mac_control}, {31'd0, ctl});
    chk({tag, ".mac_last"},    {31'd0, mac_last},    {31'd0, lst});
    chk({tag, ".done"},        {31'd0, done},        {31'd0, dn});
    chk({tag, ".err"},         {31'd0, err},         {31'd0, er});
  endtask

  task automatic chk_ops(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    chk({tag, ".mac_a"}, mac_a, ea);
    chk({tag, ".mac_b"}, mac_b, eb);
  endtask

  initial begin
    wtab[0] = F1; wtab[1] = F2; wtab[2] = F3; wtab[3] = F4; wtab[4] = F5;
    reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = 32'd0;
    start = 1'b0; vec_len = '0; act_valid = 1'b0; act_data = 32'd0;
    step(); step();
    chk_st("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("reset", 32'd0, 32'd0);
    reset = 1'b0;

    // Load w[i] = i+1.0
    for (int i = 0; i < 5; i++) begin
      w_we = 1'b1; w_addr = AW'(i); w_data = wtab[i];
      step();
    end
    w_we = 1'b0;

    // Vector of 4, back-to-back accepts of 2.0
    start = 1'b1; vec_len = 7'd4;
    step();
    start = 1'b0;
    chk_st("v4.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    act_valid = 1'b1; act_data = F2;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_st($sformatf("v4.beat%0d", k), (k != 3), 1'b1, 1'b1, (k == 0), (k == 3), (k == 3), 1'b0);
      chk_ops($sformatf("v4.beat%0d", k), F2, wtab[k]);
    end
    act_valid = 1'b0;
    step();
    chk_st("v4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("v4.hold", F2, F4);

    // Vector of 3 with a two-cycle gap between elements 1 and 2
    start = 1'b1; vec_len = 7'd3;
    step();
    start = 1'b0;
    act_valid = 1'b1; act_data = F3;
    step();
    chk_st("v3.beat0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ops("v3.beat0", F3, F1);
    act_data = F4;
    step();
    chk_st("v3.beat1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("v3.beat1", F4, F2);
    act_valid = 1'b0; act_data = F9;
    step();
    chk_st("v3.gap0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("v3.gap0", F4, F2);
    step();
    chk_st("v3.gap1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("v3.gap1", F4, F2);
    act_valid = 1'b1; act_data = F5;
    step();
    chk_st("v3.beat2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_ops("v3.beat2", F5, F3);
    act_valid = 1'b0;
    step();
    chk_st("v3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Vector of 1
    start = 1'b1; vec_len = 7'd1;
    step();
    start = 1'b0;
    act_valid = 1'b1; act_data = F5;
    step();
    chk_st("v1.beat", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_ops("v1.beat", F5, F1);
    act_valid = 1'b0;
    step();
    chk_st("v1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal lengths: 0 and DEPTH+1
    start = 1'b1; vec_len = 7'd0;
    step();
    start = 1'b0;
    chk_st("len0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_st("len0.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; vec_len = 7'd65;
    step();
    start = 1'b0;
    chk_st("len65", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_st("len65.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write during RUN is ignored; start during RUN gives no err
    start = 1'b1; vec_len = 7'd2;
    step();
    start = 1'b1; vec_len = 7'd0;
    w_we = 1'b1; w_addr = '0; w_data = F9;
    step();
    start = 1'b0; w_we = 1'b0;
    chk_st("runwr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    act_valid = 1'b1; act_data = F3;
    step();
    chk_ops("runwr.beat0", F3, F1);
    step();
    chk_st("runwr.beat1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    act_valid = 1'b0;
    step();
    start = 1'b1; vec_len = 7'd1;
    step();
    start = 1'b0; act_valid = 1'b1; act_data = F4;
    step();
    act_valid = 1'b0;
    chk_ops("runwr.next", F4, F1);
    step();

    // Reset after 2 of 5 accepts, then a full vector
    start = 1'b1; vec_len = 7'd5;
    step();
    start = 1'b0; act_valid = 1'b1; act_data = F2;
    step(); step();
    reset = 1'b1; act_valid = 1'b0;
    step();
    reset = 1'b0;
    chk_st("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ops("rst.mid", 32'd0, 32'd0);
    step();
    chk_st("rst.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; vec_len = 7'd5;
    step();
    start = 1'b0; act_valid = 1'b1; act_data = F9;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_st($sformatf("v5.beat%0d", k), (k != 4), 1'b1, 1'b1, (k == 0), (k == 4), (k == 4), 1'b0);
      chk_ops($sformatf("v5.beat%0d", k), F9, wtab[k]);
    end
    act_valid = 1'b0;
    step();
    chk_st("v5.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synapse_feeder.md
SYNAPSE_FEEDER -- requirements
Module: synapse_feeder

Interface
REQ-001 Parameter DEPTH, default 64, meaning weight memory depth and maximum vector length.
REQ-002 Parameter AW, default 6, meaning weight address width, equal to clog2(DEPTH).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 w_we  in  1  weight write strobe.
REQ-006 w_addr  in  AW  weight write address.
REQ-007 w_data  in  32  weight, IEEE-754 single.
REQ-008 start  in  1  single-cycle request to begin one dot-product vector.
REQ-009 vec_len  in  AW+1  vector length, legal range 1..DEPTH, sampled with start.
REQ-010 act_valid  in  1  upstream activation valid.
REQ-011 act_data  in  32  activation, IEEE-754 single.
REQ-012 act_ready  out  1  block accepts an activation this cycle.
REQ-013 mac_ivalid  out  1  valid strobe to the downstream MAC stage.
REQ-014 mac_control  out  1  first-element flag, restarts the MAC accumulation.
REQ-015 mac_a  out  32  activation operand.
REQ-016 mac_b  out  32  weight operand.
REQ-017 mac_last  out  1  last element of the vector.
REQ-018 busy  out  1  high in RUN and DRAIN.
REQ-019 done  out  1  one-cycle pulse, coincident with the mac_last beat.
REQ-020 err  out  1  one-cycle pulse when start is rejected.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-022 IDLE SHALL go to RUN on start with vec_len in 1..DEPTH, latching len and clearing idx to 0.
REQ-023 In IDLE, start with vec_len of 0 or greater than DEPTH SHALL be ignored, and err SHALL pulse in the next cycle.
REQ-024 Weight writes (w_we) SHALL take effect only in IDLE and SHALL be ignored in RUN and DRAIN.
REQ-025 A write and start in the same IDLE cycle SHALL both take effect.
REQ-026 act_ready SHALL be 1 only in RUN, with no combinational path from act_valid.
REQ-027 An accept is act_valid and act_ready high in the same cycle.
REQ-028 On an accept, the block SHALL read weight[idx] synchronously and increment idx.
REQ-029 Exactly one cycle after an accept, the block SHALL drive mac_ivalid=1, mac_a=registered act_data and mac_b=weight[idx].
REQ-030 On that beat, mac_control SHALL be 1 iff idx==0 and mac_last SHALL be 1 iff idx==len-1.
REQ-031 Operand latency SHALL be fixed at 1 cycle from accept, with no bubbles inserted by the block.
REQ-032 A cycle without an accept SHALL produce mac_ivalid=0, mac_control=0 and mac_last=0 one cycle later, with mac_a and mac_b holding their last values.
REQ-033 The accept at idx==len-1 SHALL move the FSM to DRAIN, dropping act_ready in the next cycle.
REQ-034 DRAIN SHALL last one cycle, during which the last beat, mac_last and done are output.
REQ-035 DRAIN SHALL then return to IDLE.
REQ-036 The earliest next start SHALL be the cycle after DRAIN.
REQ-037 start in RUN or DRAIN SHALL be ignored, with no err pulse.
REQ-038 For len==1, the single beat SHALL carry mac_control=1 and mac_last=1 together.
REQ-039 idx SHALL never exceed len-1 and SHALL never wrap within a vector.
REQ-040 The block SHALL NOT apply backpressure from downstream, since the MAC is always ready.
REQ-041 The block SHALL perform no arithmetic on operands; data passes bit-exact.

Reset
REQ-042 On reset, the FSM SHALL go to IDLE and idx and len SHALL clear to 0.
REQ-043 On reset, act_ready, mac_ivalid, mac_control, mac_last, busy, done and err SHALL be 0, and mac_a and mac_b SHALL be 0.
REQ-044 Weight memory contents SHALL NOT be cleared by reset.
REQ-045 Reset asserted mid-vector SHALL abort the vector, with no done or mac_last emitted afterwards.

Verification
REQ-046 Write weights w[i]=i+1.0, start with vec_len=4, 4 back-to-back accepts of 2.0 -> 4 consecutive beats, mac_b=1.0,2.0,3.0,4.0, mac_control on beat 0 only, mac_last and done on beat 3.
REQ-047 vec_len=3 with act_valid low for 2 cycles between elements 1 and 2 -> mac_ivalid gap of exactly 2 cycles, operands held, mac_last on the third beat.
REQ-048 vec_len=1 -> single beat with mac_control=1, mac_last=1 and done=1; busy falls the cycle after.
REQ-049 start with vec_len=0, and separately with DEPTH+1 -> err pulse, FSM stays IDLE, act_ready stays 0.
REQ-050 w_we to address 0 during RUN with value 9.0, then a new vector -> mac_b for idx 0 still equals the old weight.
REQ-051 reset after 2 of 5 accepts -> all outputs 0 next cycle, no done, weights retained, and the next vector runs correctly.
